sump_cmd_decoder: RTL and testbench

Parametrised SUMP command decoder for the logic-analyzer core. It consumes the byte stream from the UART receiver and parses short (1-byte) and long (opcode + 4-byte) commands. It holds the capture configuration registers: sample divider, read/delay counts, and multi-stage edge triggers. It issues single-cycle control strobes to the sampler, trigger unit and metadata transmitter, and supersedes the fixed 8-channel, single-stage decoder.

---
 rtl/sump_cmd_decoder.sv | 191 +++++++++++++++++++
 tb/tb_sump_cmd_decoder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sump_cmd_decoder.sv
// SUMP command parser: short/long opcodes, capture config registers, strobes.
// Define SUMP_TIMEOUT_EN to enable the inter-byte payload timeout.
module sump_cmd_decoder #(
   parameter int SAMPLE_WIDTH   = 8,
   parameter int NUM_STAGES     = 1,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                               system_clock,
   input  logic                               reset,
   input  logic [7:0]                         rx_data,
   input  logic                               rx_valid,
   output logic                               sump_reset,
   output logic                               full_reset,
   output logic                               arm,
   output logic                               query_meta,
   output logic                               query_id,
   output logic                               cfg_update,
   output logic                               cmd_error,
   output logic                               cmd_timeout,
   output logic [23:0]                        divider,
   output logic [15:0]                        read_count,
   output logic [15:0]                        delay_count,
   output logic [NUM_STAGES*SAMPLE_WIDTH-1:0] trig_rise,
   output logic [NUM_STAGES*SAMPLE_WIDTH-1:0] trig_fall,
   output logic [NUM_STAGES-1:0]              stage_en
);

   localparam int SW = SAMPLE_WIDTH;
   localparam int NS = NUM_STAGES;

   if (SW < 1 || SW > 16 || NS < 1 || NS > 4 || TIMEOUT_CYCLES < 2) begin : g_bad_param
      $error("sump_cmd_decoder: parameter out of range");
   end

   typedef enum logic {ST_IDLE, ST_PAYLOAD} state_t;

   state_t         r_state, w_state_nx;
   logic [1:0]     r_idx;
   logic [7:0]     r_op;
   logic [23:0]    r_w;
   logic [2:0]     r_rcnt;

   logic           r_sump_reset, r_full_reset, r_arm, r_query_meta, r_query_id;
   logic           r_cfg_update, r_cmd_error, r_cmd_timeout;
   logic [23:0]    r_divider;
   logic [15:0]    r_read_count, r_delay_count;
   logic [NS*SW-1:0] r_trig_rise, r_trig_fall;
   logic [NS-1:0]  r_stage_en;

   logic [31:0]    w_word;
   logic [3:0]     w_stage;
   logic [SW-1:0]  w_rise, w_fall;
   logic           w_short, w_zero, w_full, w_last, w_tmo, w_in_range;
   logic           w_is_div, w_is_cnt, w_is_trig, w_is_en, w_err;

   // Fourth payload byte completes the word combinationally so all fields land together.
   assign w_word     = {r_w, rx_data};
   assign w_stage    = r_op[5:2];
   assign w_rise     = SW'({w_word[23:16], w_word[7:0]});
   assign w_fall     = SW'({w_word[31:24], w_word[15:8]});
   assign w_short    = (r_state == ST_IDLE) && rx_valid && !rx_data[7];
   assign w_zero     = w_short && (rx_data == 8'h00);
   assign w_full     = w_zero && (r_rcnt == 3'd4);
   assign w_last     = (r_state == ST_PAYLOAD) && rx_valid && (r_idx == 2'd3);
   assign w_in_range = (r_op[7:6] == 2'b11) && (int'(w_stage) < NS);
   assign w_is_div   = w_last && (r_op == 8'h80);
   assign w_is_cnt   = w_last && (r_op == 8'h81);
   assign w_is_trig  = w_last && w_in_range && (r_op[1:0] == 2'b01);
   assign w_is_en    = w_last && w_in_range && (r_op[1:0] == 2'b10);
   assign w_err      = w_last && !(w_is_div || w_is_cnt || w_is_trig || w_is_en);

`ifdef SUMP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tcnt;

   assign w_tmo = (r_state == ST_PAYLOAD) && !rx_valid &&
                  (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge system_clock or posedge reset) begin
      if (reset)
         r_tcnt <= '0;
      else if (r_state != ST_PAYLOAD || rx_valid)
         r_tcnt <= '0;
      else
         r_tcnt <= r_tcnt + TW'(1);
   end
`else
   assign w_tmo = 1'b0;
`endif

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         ST_IDLE:    if (rx_valid && rx_data[7]) w_state_nx = ST_PAYLOAD;
         ST_PAYLOAD: if (w_last || w_tmo) w_state_nx = ST_IDLE;
         default:    w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_idx   <= 2'd0;
         r_op    <= 8'h00;
         r_w     <= 24'h0;
         r_rcnt  <= 3'd0;
      end else begin
         r_state <= w_state_nx;
         if (r_state == ST_IDLE && rx_valid && rx_data[7]) begin
            r_op  <= rx_data;
            r_idx <= 2'd0;
         end else if (r_state == ST_PAYLOAD && rx_valid) begin
            r_w   <= w_word[23:0];
            r_idx <= r_idx + 2'd1;
         end
         if (w_full)
            r_rcnt <= 3'd0;
         else if (w_zero)
            r_rcnt <= r_rcnt + 3'd1;
         else if ((r_state == ST_IDLE && rx_valid) || w_tmo)
            r_rcnt <= 3'd0;
      end
   end

   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         r_sump_reset  <= 1'b0;
         r_full_reset  <= 1'b0;
         r_arm         <= 1'b0;
         r_query_meta  <= 1'b0;
         r_query_id    <= 1'b0;
         r_cfg_update  <= 1'b0;
         r_cmd_error   <= 1'b0;
         r_cmd_timeout <= 1'b0;
         r_divider     <= 24'h0;
         r_read_count  <= 16'h0;
         r_delay_count <= 16'h0;
         r_trig_rise   <= '0;
         r_trig_fall   <= '0;
         r_stage_en    <= '0;
      end else begin
         r_sump_reset  <= w_zero;
         r_full_reset  <= w_full;
         r_arm         <= w_short && (rx_data == 8'h01);
         r_query_meta  <= w_short && (rx_data == 8'h02);
         r_query_id    <= w_short && (rx_data == 8'h04);
         r_cfg_update  <= w_is_div || w_is_cnt || w_is_trig || w_is_en;
         r_cmd_error   <= w_err;
         r_cmd_timeout <= w_tmo;
         if (w_full) begin
            r_divider     <= 24'h0;
            r_read_count  <= 16'h0;
            r_delay_count <= 16'h0;
            r_trig_rise   <= '0;
            r_trig_fall   <= '0;
            r_stage_en    <= '0;
         end else begin
            if (w_is_div) r_divider <= w_word[23:0];
            if (w_is_cnt) begin
               r_read_count  <= w_word[31:16];
               r_delay_count <= w_word[15:0];
            end
            for (int s = 0; s < NS; s++) begin
               if (w_stage == 4'(s)) begin
                  if (w_is_trig) begin
                     r_trig_rise[s*SW +: SW] <= w_rise;
                     r_trig_fall[s*SW +: SW] <= w_fall;
                  end
                  if (w_is_en) r_stage_en[s] <= w_word[0];
               end
            end
         end
      end
   end

   assign sump_reset  = r_sump_reset;
   assign full_reset  = r_full_reset;
   assign arm         = r_arm;
   assign query_meta  = r_query_meta;
   assign query_id    = r_query_id;
   assign cfg_update  = r_cfg_update;
   assign cmd_error   = r_cmd_error;
   assign cmd_timeout = r_cmd_timeout;
   assign divider     = r_divider;
   assign read_count  = r_read_count;
   assign delay_count = r_delay_count;
   assign trig_rise   = r_trig_rise;
   assign trig_fall   = r_trig_fall;
   assign stage_en    = r_stage_en;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Bench for sump_cmd_decoder: vector table, hand corner cases, random vs model.
// Timeout expectations follow SUMP_TIMEOUT_EN.
module tb_sump_cmd_decoder;

   localparam int SW  = 16;
   localparam int NS  = 2;
   localparam int TMO = 8;

   localparam logic [7:0] S_SR  = 8'h80;
   localparam logic [7:0] S_FR  = 8'h40;
   localparam logic [7:0] S_ARM = 8'h20;
   localparam logic [7:0] S_QM  = 8'h10;
   localparam logic [7:0] S_QI  = 8'h08;
   localparam logic [7:0] S_CU  = 8'h04;
   localparam logic [7:0] S_ER  = 8'h02;
   localparam logic [7:0] S_TO  = 8'h01;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic rx_valid = 1'b0;

   logic sump_reset, full_reset, arm, query_meta, query_id;
   logic cfg_update, cmd_error, cmd_timeout;
   logic [23:0] divider;
   logic [15:0] read_count, delay_count;
   logic [NS*SW-1:0] trig_rise, trig_fall;
   logic [NS-1:0] stage_en;

   always #5 clk = ~clk;

   sump_cmd_decoder #(
      .SAMPLE_WIDTH(SW), .NUM_STAGES(NS), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .system_clock(clk), .reset(rst),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .sump_reset(sump_reset), .full_reset(full_reset), .arm(arm),
      .query_meta(query_meta), .query_id(query_id),
      .cfg_update(cfg_update), .cmd_error(cmd_error),
      .cmd_timeout(cmd_timeout), .divider(divider),
      .read_count(read_count), .delay_count(delay_count),
      .trig_rise(trig_rise), .trig_fall(trig_fall), .stage_en(stage_en)
   );

   logic [7:0]   str;
   logic [121:0] cfg;
   assign str = {sump_reset, full_reset, arm, query_meta,
                 query_id, cfg_update, cmd_error, cmd_timeout};
   assign cfg = {divider, read_count, delay_count,
                 trig_rise, trig_fall, stage_en};

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic step(input bit v, input logic [7:0] d);
      @(negedge clk);
      rx_valid = v;
      rx_data  = d;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Vector table
   typedef struct {
      bit          v;
      logic [7:0]  d;
      logic [7:0]  s;
      bit          ck;
      logic [23:0] dv;
      logic [15:0] rc;
      logic [15:0] dc;
      logic [31:0] tr;
      logic [31:0] tf;
      logic [1:0]  en;
   } vec_t;

   vec_t tv[$];

   task automatic add(input bit v, input logic [7:0] d, input logic [7:0] s);
      vec_t r;
      r = '{v: v, d: d, s: s, ck: 1'b0, dv: '0, rc: '0, dc: '0,
            tr: '0, tf: '0, en: '0};
      tv.push_back(r);
   endtask

   task automatic addc(input logic [7:0] d, input logic [7:0] s,
                       input logic [23:0] dv, input logic [15:0] rc,
                       input logic [15:0] dc, input logic [31:0] tr,
                       input logic [31:0] tf, input logic [1:0] en);
      vec_t r;
      r = '{v: 1'b1, d: d, s: s, ck: 1'b1, dv: dv, rc: rc, dc: dc,
            tr: tr, tf: tf, en: en};
      tv.push_back(r);
   endtask

   // Reference model: byte queue plus decoded command semantics
   bit          m_busy;
   logic [7:0]  m_op;
   logic [7:0]  m_q[$];
   int          m_idle;
   int          m_zeros;
   logic [23:0] m_div;
   logic [15:0] m_rc, m_dc;
   logic [31:0] m_rise, m_fall;
   logic [1:0]  m_en;
   logic [7:0]  e_str;

   task automatic model_reset();
      m_busy = 0; m_op = 0; m_q.delete(); m_idle = 0; m_zeros = 0;
      m_div = 0; m_rc = 0; m_dc = 0; m_rise = 0; m_fall = 0; m_en = 0;
   endtask

   task automatic model_exec();
      logic [31:0] wd;
      int k, n;
      wd = {m_q[0], m_q[1], m_q[2], m_q[3]};
      k = int'(m_op) - 'hC1;
      n = k / 4;
      if (m_op == 8'h80) begin
         m_div = wd[23:0]; e_str |= S_CU;
      end else if (m_op == 8'h81) begin
         m_rc = wd[31:16]; m_dc = wd[15:0]; e_str |= S_CU;
      end else if (k >= 0 && k % 4 == 0 && n < NS) begin
         m_rise[16*n +: 16] = {m_q[1], m_q[3]};
         m_fall[16*n +: 16] = {m_q[0], m_q[2]};
         e_str |= S_CU;
      end else if (k >= 0 && k % 4 == 1 && n < NS) begin
         m_en[n] = wd[0]; e_str |= S_CU;
      end else begin
         e_str |= S_ER;
      end
   endtask

   task automatic model(input bit v, input logic [7:0] d);
      e_str = 8'h00;
      if (!m_busy) begin
         if (v && d[7]) begin
            m_busy = 1; m_op = d; m_q.delete(); m_idle = 0; m_zeros = 0;
         end else if (v) begin
            if (d == 8'h00) e_str |= S_SR;
            if (d == 8'h01) e_str |= S_ARM;
            if (d == 8'h02) e_str |= S_QM;
            if (d == 8'h04) e_str |= S_QI;
            m_zeros = (d == 8'h00) ? m_zeros + 1 : 0;
            if (m_zeros == 5) begin
               e_str |= S_FR; m_zeros = 0;
               m_div = 0; m_rc = 0; m_dc = 0;
               m_rise = 0; m_fall = 0; m_en = 0;
            end
         end
      end else if (v) begin
         m_q.push_back(d);
         m_idle = 0;
         if (m_q.size() == 4) begin
            m_busy = 0;
            model_exec();
         end
      end else begin
`ifdef SUMP_TIMEOUT_EN
         m_idle++;
         if (m_idle == TMO) begin
            m_busy = 0; e_str |= S_TO; m_zeros = 0;
         end
`endif
      end
   endtask

   function automatic logic [7:0] pick();
      int r;
      r = $urandom_range(0, 17);
      case (r)
         0, 1, 2, 3, 4: return 8'h00;
         5:  return 8'h01;
         6:  return 8'h02;
         7:  return 8'h03;
         8:  return 8'h04;
         9:  return 8'h80;
         10: return 8'h81;
         11: return 8'hC1;
         12: return 8'hC2;
         13: return 8'hC5;
         14: return 8'hC6;
         15: return 8'hC9;
         16: return 8'hCA;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic rstep(input bit v, input logic [7:0] d);
      model(v, d);
      step(v, d);
      chk("rnd_strobes", str, e_str);
      chk("rnd_cfg", cfg, {m_div, m_rc, m_dc, m_rise, m_fall, m_en});
   endtask

   logic [7:0] eb [4] = '{8'h00, 8'h2A, 8'h00, 8'h3B};

   initial begin
      // Table: test-plan byte streams, one row per cycle
      add(0, 8'h00, 8'h00);
      add(1, 8'h01, S_ARM);
      add(1, 8'h80, 0); add(1, 8'h00, 0); add(1, 8'h00, 0); add(1, 8'h01, 0);
      addc(8'hF3, S_CU, 24'h1F3, 16'h0, 16'h0, 32'h0, 32'h0, 2'b00);
      add(1, 8'h81, 0); add(1, 8'h00, 0); add(1, 8'h18, 0); add(1, 8'h00, 0);
      addc(8'h18, S_CU, 24'h1F3, 16'h18, 16'h18, 32'h0, 32'h0, 2'b00);
      add(1, 8'hC5, 0); add(1, 8'h12, 0); add(1, 8'h34, 0); add(1, 8'h56, 0);
      addc(8'h78, S_CU, 24'h1F3, 16'h18, 16'h18,
           32'h3478_0000, 32'h1256_0000, 2'b00);
      add(1, 8'hC6, 0); add(1, 8'h00, 0); add(1, 8'h00, 0); add(1, 8'h00, 0);
      addc(8'h01, S_CU, 24'h1F3, 16'h18, 16'h18,
           32'h3478_0000, 32'h1256_0000, 2'b10);
      add(1, 8'hC9, 0); add(1, 8'hAA, 0); add(1, 8'hBB, 0); add(1, 8'hCC, 0);
      addc(8'hDD, S_ER, 24'h1F3, 16'h18, 16'h18,
           32'h3478_0000, 32'h1256_0000, 2'b10);
      add(1, 8'h03, 0);
      add(1, 8'h02, S_QM);
      add(1, 8'h04, S_QI);
      add(1, 8'h00, S_SR); add(1, 8'h00, S_SR); add(1, 8'h01, S_ARM);
      add(1, 8'h00, S_SR);
      addc(8'h00, S_SR, 24'h1F3, 16'h18, 16'h18,
           32'h3478_0000, 32'h1256_0000, 2'b10);
      add(1, 8'h02, S_QM);
      for (int i = 0; i < 4; i++) add(1, 8'h00, S_SR);
      addc(8'h00, S_SR | S_FR, 24'h0, 16'h0, 16'h0, 32'h0, 32'h0, 2'b00);
      add(1, 8'h00, S_SR);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_strobes", str, 8'h00);
      chk("reset_cfg", cfg, 122'h0);
      rst = 1'b0;

      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i].v, tv[i].d);
         chk($sformatf("vec%0d_strobes", i), str, tv[i].s);
         if (tv[i].ck)
            chk($sformatf("vec%0d_cfg", i), cfg,
                {tv[i].dv, tv[i].rc, tv[i].dc, tv[i].tr, tv[i].tf, tv[i].en});
      end

      // Bytes arriving exactly in the expiry cycle are accepted
      step(1, 8'h81);
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < TMO - 1; j++) begin
            step(0, 8'h00);
            chk("expiry_idle", str, 8'h00);
         end
         step(1, eb[k]);
         chk("expiry_byte", str, (k == 3) ? S_CU : 8'h00);
      end
      chk("expiry_cfg", {read_count, delay_count}, 32'h002A_003B);

      // Payload stalls for a full timeout window
      step(1, 8'h81); step(1, 8'h00); step(1, 8'h77);
      for (int j = 1; j <= TMO; j++) begin
         step(0, 8'h00);
`ifdef SUMP_TIMEOUT_EN
         chk("tmo_idle", str, (j == TMO) ? S_TO : 8'h00);
`else
         chk("tmo_idle", str, 8'h00);
`endif
      end
`ifdef SUMP_TIMEOUT_EN
      chk("tmo_cfg_kept", {read_count, delay_count}, 32'h002A_003B);
      step(1, 8'h04);
      chk("tmo_query_id", str, S_QI);
`else
      step(1, 8'h04);
      chk("notmo_04_payload", str, 8'h00);
      step(1, 8'h00);
      chk("notmo_complete", str, S_CU);
      chk("notmo_cfg", {read_count, delay_count}, 32'h0077_0400);
`endif

      // Asynchronous reset mid-payload drops the partial command
      step(1, 8'hC1); step(1, 8'hAA);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_strobes", str, 8'h00);
      chk("async_rst_cfg", cfg, 122'h0);
      @(negedge clk);
      rst = 1'b0;
      step(1, 8'h01);
      chk("async_rst_arm", str, S_ARM);
      step(0, 8'h00);
      chk("arm_one_cycle", str, 8'h00);

      // Randomized traffic against the reference model
      do_reset();
      model_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            int g;
            g = $urandom_range(1, 10);
            for (int j = 0; j < g; j++) rstep(0, 8'h00);
         end
         rstep(1, pick());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
